// File: rtl/hdlc_buf_pkg.sv
// Shared register map, address-region codes and LEN field layout for the HDLC receive buffer.
// Constants only. No timing or flow-control behaviour lives here.
package hdlc_buf_pkg;

    localparam logic [7:0] REG_STATUS    = 8'h00;
    localparam logic [7:0] REG_IRQ_EN    = 8'h01;
    localparam logic [7:0] REG_LEN_BASE  = 8'h02;
    localparam logic [7:0] REG_DROP_BASE = 8'h10;

    localparam logic [3:0] REGION_REG     = 4'h0;
    localparam logic [3:0] REGION_CH_BASE = 4'h1;

    localparam int LEN_BANK_BIT = 15;
    localparam int LEN_OVF_BIT  = 14;
    localparam int LEN_CNT_W    = 13;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

    function automatic logic [15:0] pack_len(input logic                 bank,
                                             input logic                 ovf,
                                             input logic [LEN_CNT_W-1:0] cnt);
        logic [15:0] w;
        w               = {3'b000, cnt};
        w[LEN_BANK_BIT] = bank;
        w[LEN_OVF_BIT]  = ovf;
        return w;
    endfunction

endpackage

// File: rtl/hdlc_rx_chan.sv
// One receive channel: ping-pong byte RAM, writer FSM, pending/LEN/DROP registers.
// The RAM read data is registered one cycle after rd_addr. There is no backpressure: a frame that ends while the other bank is still pending is counted and discarded.
module hdlc_rx_chan
    import hdlc_buf_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    input  logic                     byte_vld,
    input  logic [7:0]               byte_dat,
    input  logic                     frame_end,
    input  logic                     frame_abort,
    input  logic                     rel,
    input  logic                     drop_clr,
    input  logic [$clog2(DEPTH):0]   rd_addr,
    output logic [7:0]               rd_dat,
    output logic                     pending,
    output logic [15:0]              len,
    output logic [15:0]              drop
);

    localparam int AW = $clog2(DEPTH);

    wr_state_e   state_q;
    logic [AW:0] wr_ptr_q;
    logic        ovf_q;
    logic        wbank_q;

    logic        pending_q, pending_d;
    logic [15:0] len_q, len_d;
    logic [15:0] drop_q, drop_d;

    logic        full;
    logic        byte_ok;
    logic [AW:0] cnt_eff;
    logic        ovf_eff;
    logic        has_data;
    logic        frame_done;
    logic        pend_eff;
    logic        publish;

    logic [7:0]  mem [2*DEPTH];
    logic [7:0]  rd_dat_q;

    // A byte arriving with frame_end belongs to the frame; with abort it is dropped.
    // An abort that coincides with frame_end takes priority.
    always_comb begin
        full       = wr_ptr_q[AW];
        byte_ok    = byte_vld && !full && !frame_abort;
        cnt_eff    = wr_ptr_q + {{AW{1'b0}}, byte_ok};
        ovf_eff    = ovf_q || (byte_vld && full);
        has_data   = (state_q == WR_FILL) || byte_vld;
        frame_done = frame_end && !frame_abort && has_data;
        pend_eff   = pending_q && !rel;
        publish    = frame_done && !pend_eff;

        pending_d  = pend_eff || publish;
        len_d      = publish ? pack_len(wbank_q, ovf_eff, LEN_CNT_W'(cnt_eff)) : len_q;
        drop_d     = drop_q;
        if (frame_done && pend_eff && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (drop_clr) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WR_IDLE;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            wbank_q  <= 1'b0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (frame_abort || frame_end) begin
                        wr_ptr_q <= '0;
                        ovf_q    <= 1'b0;
                        if (publish) begin
                            wbank_q <= ~wbank_q;
                        end
                    end else if (byte_vld) begin
                        state_q  <= WR_FILL;
                        wr_ptr_q <= cnt_eff;
                    end
                end
                default: begin
                    if (frame_abort || frame_end) begin
                        state_q  <= WR_IDLE;
                        wr_ptr_q <= '0;
                        ovf_q    <= 1'b0;
                        if (publish) begin
                            wbank_q <= ~wbank_q;
                        end
                    end else if (byte_vld) begin
                        wr_ptr_q <= cnt_eff;
                        ovf_q    <= ovf_eff;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            len_q     <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (byte_ok) begin
            mem[{wbank_q, wr_ptr_q[AW-1:0]}] <= byte_dat;
        end
        rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat  = rd_dat_q;
    assign pending = pending_q;
    assign len     = len_q;
    assign drop    = drop_q;

endmodule

// File: rtl/hdlc_rx_pingpong_buf.sv
// Multi-channel HDLC receive ping-pong buffer with an EMIF register/buffer window and a maskable level IRQ.
// Read data appears two cycles after emif_ren and holds until the next read. Writes act at the strobe edge; receive input is never stalled.
module hdlc_rx_pingpong_buf
    import hdlc_buf_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 256
) (
    input  logic               clk_100m,
    input  logic               rst_n,
    input  logic [NCH-1:0]     rx_byte_vld,
    input  logic [8*NCH-1:0]   rx_byte,
    input  logic [NCH-1:0]     rx_frame_end,
    input  logic [NCH-1:0]     rx_frame_abort,
    input  logic               emif_wen,
    input  logic               emif_ren,
    input  logic [23:0]        emif_addr,
    input  logic [15:0]        emif_wdata,
    output logic [15:0]        emif_rdata,
    output logic               irq
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]     region;
    logic [7:0]     off;
    logic           reg_sel;
    logic           buf_sel;
    logic [2:0]     ch_idx;
    logic           reg_wr;

    logic [NCH-1:0] rel;
    logic [NCH-1:0] drop_clr;
    logic [NCH-1:0] pending;
    logic [7:0]     rd_dat [NCH];
    logic [15:0]    len    [NCH];
    logic [15:0]    drop   [NCH];

    logic [NCH-1:0] irq_en_q, irq_en_d;
    logic           irq_q, irq_d;
    logic [15:0]    reg_rdat;

    logic           ren_s1_q, ren_s1_d;
    logic           reg_sel_s1_q, reg_sel_s1_d;
    logic           buf_sel_s1_q, buf_sel_s1_d;
    logic [2:0]     ch_s1_q, ch_s1_d;
    logic [15:0]    reg_dat_s1_q, reg_dat_s1_d;
    logic [7:0]     buf_dat;
    logic [15:0]    rdata_q, rdata_d;

    logic           unused_bits;
    assign unused_bits = ^{emif_addr[23:20], emif_addr[15:8], emif_wdata};

    always_comb begin
        region  = emif_addr[19:16];
        off     = emif_addr[7:0];
        reg_sel = (region == REGION_REG);
        buf_sel = (region >= REGION_CH_BASE) && (region < (REGION_CH_BASE + 4'(NCH)));
        ch_idx  = 3'(region - REGION_CH_BASE);
        reg_wr  = emif_wen && reg_sel;

        for (int c = 0; c < NCH; c++) begin
            rel[c]      = reg_wr && (off == REG_STATUS) && emif_wdata[c];
            drop_clr[c] = reg_wr && (off == (REG_DROP_BASE + 8'(c)));
        end

        irq_en_d = (reg_wr && (off == REG_IRQ_EN)) ? emif_wdata[NCH-1:0] : irq_en_q;
        irq_d    = |(pending & irq_en_q);
    end

    // Register values are snapshotted on the read strobe so they line up with the RAM read stage.
    always_comb begin
        reg_rdat = '0;
        if (off == REG_STATUS) begin
            reg_rdat[NCH-1:0] = pending;
        end else if (off == REG_IRQ_EN) begin
            reg_rdat[NCH-1:0] = irq_en_q;
        end
        for (int c = 0; c < NCH; c++) begin
            if (off == (REG_LEN_BASE + 8'(c))) begin
                reg_rdat = len[c];
            end
            if (off == (REG_DROP_BASE + 8'(c))) begin
                reg_rdat = drop[c];
            end
        end
    end

    always_comb begin
        ren_s1_d     = emif_ren;
        reg_sel_s1_d = reg_sel_s1_q;
        buf_sel_s1_d = buf_sel_s1_q;
        ch_s1_d      = ch_s1_q;
        reg_dat_s1_d = reg_dat_s1_q;
        if (emif_ren) begin
            reg_sel_s1_d = reg_sel;
            buf_sel_s1_d = buf_sel;
            ch_s1_d      = ch_idx;
            reg_dat_s1_d = reg_rdat;
        end

        buf_dat = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_s1_q == 3'(c)) begin
                buf_dat = rd_dat[c];
            end
        end

        rdata_d = rdata_q;
        if (ren_s1_q) begin
            if (reg_sel_s1_q) begin
                rdata_d = reg_dat_s1_q;
            end else if (buf_sel_s1_q) begin
                rdata_d = {8'h00, buf_dat};
            end else begin
                rdata_d = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
            ren_s1_q     <= 1'b0;
            reg_sel_s1_q <= 1'b0;
            buf_sel_s1_q <= 1'b0;
            ch_s1_q      <= '0;
            reg_dat_s1_q <= '0;
            rdata_q      <= '0;
        end else begin
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            ren_s1_q     <= ren_s1_d;
            reg_sel_s1_q <= reg_sel_s1_d;
            buf_sel_s1_q <= buf_sel_s1_d;
            ch_s1_q      <= ch_s1_d;
            reg_dat_s1_q <= reg_dat_s1_d;
            rdata_q      <= rdata_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        hdlc_rx_chan #(
            .DEPTH(DEPTH)
        ) u_chan (
            .clk_100m    (clk_100m),
            .rst_n       (rst_n),
            .byte_vld    (rx_byte_vld[c]),
            .byte_dat    (rx_byte[8*c +: 8]),
            .frame_end   (rx_frame_end[c]),
            .frame_abort (rx_frame_abort[c]),
            .rel         (rel[c]),
            .drop_clr    (drop_clr[c]),
            .rd_addr     (emif_addr[AW:0]),
            .rd_dat      (rd_dat[c]),
            .pending     (pending[c]),
            .len         (len[c]),
            .drop        (drop[c])
        );
    end

    assign emif_rdata = rdata_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_hdlc_rx_pingpong_buf.sv
// Scenario bench for hdlc_rx_pingpong_buf: read expectations queue up at the strobe and are compared when data returns.
module tb_hdlc_rx_pingpong_buf;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;

    localparam logic [23:0] R_STATUS = 24'h000000;
    localparam logic [23:0] R_IRQ_EN = 24'h000001;
    localparam logic [23:0] R_LEN0   = 24'h000002;
    localparam logic [23:0] R_DROP0  = 24'h000010;

    logic               clk_100m = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     rx_byte_vld;
    logic [8*NCH-1:0]   rx_byte;
    logic [NCH-1:0]     rx_frame_end;
    logic [NCH-1:0]     rx_frame_abort;
    logic               emif_wen;
    logic               emif_ren;
    logic [23:0]        emif_addr;
    logic [15:0]        emif_wdata;
    logic [15:0]        emif_rdata;
    logic               irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    logic    ren_h1 = 1'b0;
    logic    ren_h2 = 1'b0;

    hdlc_rx_pingpong_buf #(
        .NCH   (NCH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_100m       (clk_100m),
        .rst_n          (rst_n),
        .rx_byte_vld    (rx_byte_vld),
        .rx_byte        (rx_byte),
        .rx_frame_end   (rx_frame_end),
        .rx_frame_abort (rx_frame_abort),
        .emif_wen       (emif_wen),
        .emif_ren       (emif_ren),
        .emif_addr      (emif_addr),
        .emif_wdata     (emif_wdata),
        .emif_rdata     (emif_rdata),
        .irq            (irq)
    );

    always #5 clk_100m = ~clk_100m;

    // Read data is due on the second falling edge after the strobe was sampled.
    always @(posedge clk_100m) begin
        ren_h1 <= emif_ren;
        ren_h2 <= ren_h1;
    end

    always @(negedge clk_100m) begin
        rd_exp_t e;
        if (ren_h2 === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h with no expected entry", emif_rdata);
            end else begin
                e = sb_q.pop_front();
                if (emif_rdata !== e.exp) begin
                    errors++;
                    $display("FAIL rd addr=%h: got %h exp %h", e.addr, emif_rdata, e.exp);
                end
            end
        end
    end

    function automatic logic [23:0] badr(input int c, input int b, input int i);
        return 24'((c + 1) * 65536 + b * DEPTH + i);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic set_lanes(input logic [7:0] v);
        for (int c = 0; c < NCH; c++) rx_byte[8*c +: 8] = v;
    endtask

    task automatic send(input logic [NCH-1:0] mask, input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            rx_byte_vld = mask;
            set_lanes(start + 8'(i));
            @(negedge clk_100m);
        end
        rx_byte_vld = '0;
    endtask

    task automatic pulse_end(input logic [NCH-1:0] mask);
        rx_frame_end = mask;
        @(negedge clk_100m);
        rx_frame_end = '0;
    endtask

    task automatic pulse_abort(input logic [NCH-1:0] mask);
        rx_frame_abort = mask;
        @(negedge clk_100m);
        rx_frame_abort = '0;
    endtask

    task automatic wr(input logic [23:0] addr, input logic [15:0] data);
        emif_wen   = 1'b1;
        emif_addr  = addr;
        emif_wdata = data;
        @(negedge clk_100m);
        emif_wen   = 1'b0;
    endtask

    task automatic rd(input logic [23:0] addr, input logic [15:0] exp);
        rd_exp_t e;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
        emif_ren  = 1'b1;
        emif_addr = addr;
        @(negedge clk_100m);
        emif_ren  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (emif_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h exp 0000", emif_rdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b exp 0", irq);
        end
        rd(R_STATUS, 16'h0000);
        rd(R_IRQ_EN, 16'h0000);
        rd(R_LEN0, 16'h0000);
        rd(R_DROP0, 16'h0000);
        rd(R_DROP0 + 24'd3, 16'h0000);
        tick(2);
    endtask

    task automatic test_publish();
        wr(R_IRQ_EN, 16'h0001);
        send(4'h1, 8'hA1, 5);
        pulse_end(4'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL publish_irq_lag: got %b exp 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL publish_irq: got %b exp 1", irq);
        end
        rd(R_STATUS, 16'h0001);
        rd(R_LEN0, 16'h0005);
        rd(R_IRQ_EN, 16'h0001);
        for (int i = 0; i < 5; i++) rd(badr(0, 0, i), 16'h00A1 + 16'(i));
        rd(24'hF10000, 16'h00A1);
        rd(24'h050000, 16'h0000);
        rd(24'h000007, 16'h0000);
        tick(2);
    endtask

    task automatic test_drop();
        send(4'h1, 8'hB1, 3);
        pulse_end(4'h1);
        rd(R_DROP0, 16'h0001);
        rd(R_STATUS, 16'h0001);
        rd(R_LEN0, 16'h0005);
        send(4'h1, 8'h60, 2);
        rx_frame_end = 4'h1;
        emif_wen     = 1'b1;
        emif_addr    = R_DROP0;
        emif_wdata   = 16'h1234;
        @(negedge clk_100m);
        rx_frame_end = '0;
        emif_wen     = 1'b0;
        rd(R_DROP0, 16'h0000);
        wr(R_STATUS, 16'h0000);
        rd(R_STATUS, 16'h0001);
        tick(2);
        wr(R_STATUS, 16'h0001);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL release_irq_lag: got %b exp 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL release_irq: got %b exp 0", irq);
        end
        rd(R_STATUS, 16'h0000);
        send(4'h1, 8'hC1, 3);
        pulse_end(4'h1);
        rd(R_LEN0, 16'h8003);
        rd(badr(0, 1, 0), 16'h00C1);
        rd(badr(0, 1, 2), 16'h00C3);
        rd(badr(0, 0, 0), 16'h00A1);
        wr(R_STATUS, 16'h0001);
        tick(2);
    endtask

    task automatic test_overflow();
        send(4'h1, 8'h40, DEPTH + 4);
        pulse_end(4'h1);
        rd(R_LEN0, 16'h4010);
        rd(badr(0, 0, 0), 16'h0040);
        rd(badr(0, 0, DEPTH - 1), 16'h004F);
        wr(R_STATUS, 16'h0001);
        tick(2);
    endtask

    task automatic test_same_cycle_release();
        send(4'h2, 8'hD1, 2);
        pulse_end(4'h2);
        rd(R_STATUS, 16'h0002);
        rd(R_LEN0 + 24'd1, 16'h0002);
        send(4'h2, 8'h70, 4);
        rx_frame_end = 4'h2;
        emif_wen     = 1'b1;
        emif_addr    = R_STATUS;
        emif_wdata   = 16'h0002;
        @(negedge clk_100m);
        rx_frame_end = '0;
        emif_wen     = 1'b0;
        rd(R_STATUS, 16'h0002);
        rd(R_DROP0 + 24'd1, 16'h0000);
        rd(R_LEN0 + 24'd1, 16'h8004);
        rd(badr(1, 1, 3), 16'h0073);
        wr(R_STATUS, 16'h0002);
        tick(2);
    endtask

    task automatic test_abort();
        send(4'h4, 8'h10, 7);
        pulse_abort(4'h4);
        send(4'h4, 8'hE1, 2);
        pulse_end(4'h4);
        rd(R_LEN0 + 24'd2, 16'h0002);
        rd(badr(2, 0, 0), 16'h00E1);
        rd(badr(2, 0, 1), 16'h00E2);
        rd(R_STATUS, 16'h0004);
        pulse_end(4'h1);
        pulse_end(4'h4);
        rd(R_STATUS, 16'h0004);
        rd(R_DROP0 + 24'd2, 16'h0000);
        send(4'h8, 8'h31, 2);
        rx_byte_vld  = 4'h8;
        set_lanes(8'h33);
        rx_frame_end = 4'h8;
        @(negedge clk_100m);
        rx_byte_vld  = '0;
        rx_frame_end = '0;
        rd(R_LEN0 + 24'd3, 16'h0003);
        rd(badr(3, 0, 2), 16'h0033);
        send(4'h2, 8'h50, 2);
        rx_byte_vld    = 4'h2;
        set_lanes(8'h52);
        rx_frame_abort = 4'h2;
        @(negedge clk_100m);
        rx_byte_vld    = '0;
        rx_frame_abort = '0;
        send(4'h2, 8'h77, 1);
        pulse_end(4'h2);
        rd(R_LEN0 + 24'd1, 16'h0001);
        rd(badr(1, 0, 0), 16'h0077);
        rd(R_STATUS, 16'h000E);
        tick(2);
    endtask

    task automatic test_all_channels();
        wr(R_STATUS, 16'h000F);
        rd(R_STATUS, 16'h0000);
        wr(R_IRQ_EN, 16'h0004);
        send(4'hF, 8'h90, 2);
        pulse_end(4'hF);
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL all_irq: got %b exp 1", irq);
        end
        rd(R_STATUS, 16'h000F);
        for (int c = 0; c < NCH; c++) rd(R_LEN0 + 24'(c), 16'h8002);
        wr(R_STATUS, 16'h0001);
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL masked_irq_hold: got %b exp 1", irq);
        end
        wr(R_STATUS, 16'h0004);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL masked_irq_lag: got %b exp 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq_clear: got %b exp 0", irq);
        end
        rd(R_STATUS, 16'h000A);
        tick(3);
    endtask

    task automatic test_reset_mid_frame();
        send(4'h1, 8'h21, 3);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq: got %b exp 0", irq);
        end
        checks++;
        if (emif_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_rdata: got %h exp 0000", emif_rdata);
        end
        rd(R_STATUS, 16'h0000);
        rd(R_IRQ_EN, 16'h0000);
        rd(R_LEN0 + 24'd1, 16'h0000);
        send(4'h1, 8'h88, 2);
        pulse_end(4'h1);
        rd(R_LEN0, 16'h0002);
        rd(badr(0, 0, 0), 16'h0088);
        rd(badr(0, 0, 1), 16'h0089);
        tick(3);
    endtask

    initial begin
        rst_n          = 1'b0;
        rx_byte_vld    = '0;
        rx_byte        = '0;
        rx_frame_end   = '0;
        rx_frame_abort = '0;
        emif_wen       = 1'b0;
        emif_ren       = 1'b0;
        emif_addr      = '0;
        emif_wdata     = '0;
        tick(3);
        rst_n = 1'b1;

        test_reset();
        test_publish();
        test_drop();
        test_overflow();
        test_same_cycle_release();
        test_abort();
        test_all_channels();
        test_reset_mid_frame();

        tick(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rd_outstanding: got %0d entries exp 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hdlc_rx_pingpong_buf.md
# hdlc_rx_pingpong_buf

Multi-channel HDLC receive frame buffer between the clk_100m-domain HDLC receive decoders and the DSP EMIF slave port. Each of NCH channels has ping-pong byte banks: one bank fills while the last finished frame is held for the DSP. Completed frames are reported through memory-mapped status, length and drop-count registers and a maskable level interrupt. Replaces the single-channel receive RAM plus raw interrupt path with a channel-scalable, flow-controlled buffer.

## Interface
- NCH, 2: number of receive channels, 1..8
- DEPTH, 256: bytes per bank, power of two, 16..4096
- AW, $clog2(DEPTH): byte index width (derived, not overridden)

- clk_100m  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rx_byte_vld  in  NCH  per-channel byte strobe, one cycle per byte
- rx_byte  in  8*NCH  channel c byte on [8c+7:8c]
- rx_frame_end  in  NCH  good frame (CRC ok) closed; single-cycle pulse
- rx_frame_abort  in  NCH  frame abort/CRC error; single-cycle pulse
- emif_wen  in  1  single-cycle register write strobe
- emif_ren  in  1  single-cycle read strobe
- emif_addr  in  24  word address
- emif_wdata  in  16  write data
- emif_rdata  out  16  read data
- irq  out  1  level interrupt to DSP GPIO

## Operation
- Address decode: emif_addr[19:16] = 0 register region; = 1+c channel c buffer (c < NCH); other values read 16'h0000, writes ignored. Bits [23:20] ignored.
- Buffer region: emif_addr[AW] = bank, emif_addr[AW-1:0] = byte index; read returns {8'h00, byte}. Writes ignored.
- Registers (offset = emif_addr[7:0]):
  - 0x00 STATUS: bit c = channel c has a pending bank. Write-1-to-clear releases that bank; write 0 has no effect.
  - 0x01 IRQ_EN: bits [NCH-1:0], read/write.
  - 0x02+c LEN_c: [15] pending bank index, [14] overflow flag, [AW:0] byte count. Valid only while STATUS[c]=1. Read-only.
  - 0x10+c DROP_c: 16-bit saturating count of frames dropped because a bank was still pending. Any write clears it.
- Per-channel writer: states IDLE (wr_ptr=0) and FILL. A byte strobe writes to {wbank, wr_ptr}; wr_ptr increments. Writes beyond DEPTH-1 are discarded and set ovf.
- On rx_frame_end:
  - If STATUS[c]=0: publish the frame. STATUS[c] is set, LEN captures {wbank, ovf, count}, wbank toggles, wr_ptr and ovf reset.
  - If STATUS[c]=1: drop the frame. DROP_c is incremented (saturating at 16'hFFFF), wr_ptr and ovf reset, wbank unchanged.
- rx_frame_abort: wr_ptr and ovf reset, nothing published.
- A frame_end with count 0 is ignored entirely: nothing published, no drop counted.
- irq = |(STATUS & IRQ_EN), registered.

## Timing
- Reset values: emif_rdata 0, irq 0, STATUS 0, IRQ_EN 0, LEN 0, DROP 0, wbank 0, wr_ptr 0, ovf 0.
- Read latency: emif_addr is sampled on the emif_ren cycle N. emif_rdata is valid at N+2 (synchronous RAM read, then registered output mux) and holds until the next emif_ren. The top-level tri-state enable must be delayed by 2 cycles.
- A write takes effect at the clock edge of the emif_wen cycle.
- Publish: STATUS/LEN update 1 cycle after rx_frame_end; irq asserts 1 cycle after that.
- Byte strobe and frame_end in the same cycle: the byte is included in the frame.
- Byte strobe and abort in the same cycle: the byte is discarded.
- STATUS W1C release and frame_end in the same cycle: the release is applied first, so the frame is published and not dropped.
- DROP write and drop event in the same cycle: the write wins, result 0.
- Reset mid-frame: partial data is discarded and all state returns to reset values.

## Structure
- Package hdlc_buf_pkg: register offsets (REG_STATUS, REG_IRQ_EN, REG_LEN_BASE, REG_DROP_BASE), region codes, and a LEN field-position localparam.
- Sub-module hdlc_rx_chan, instantiated NCH times by generate. It contains the writer FSM, wbank/wr_ptr/ovf, the 2*DEPTH x 8 simple dual-port RAM, and the pending, LEN and DROP registers.
- The top level holds address decode, IRQ_EN, and the read mux and output register.

## Test plan
- Ch0 receives 5 bytes 0xA1..0xA5 then frame_end -> STATUS=0x0001, LEN_0=0x0005 (bank 0), buffer words 0x10000..0x10004 read 0x00A1..0x00A5 at ren+2. With IRQ_EN=1, irq=1.
- With ch0 bank 0 pending, a second 3-byte frame ends -> DROP_0=1, STATUS unchanged. After W1C 0x0001 and another 3-byte frame, LEN_0=0x8003 (bank 1).
- DEPTH+4 bytes then frame_end -> LEN_0 bit14=1, count=DEPTH, byte 0 not overwritten.
- Same-cycle W1C on STATUS[1] and ch1 frame_end -> STATUS[1]=1 afterwards, DROP_1=0.
- Abort after 7 bytes, then a 2-byte good frame -> LEN_c count=2, bank 0. A frame_end with no bytes produces no STATUS change.
- NCH=4: simultaneous frame_end on all channels -> STATUS=0xF. Masked with IRQ_EN=0x4, irq=1 until STATUS[2] is cleared, then irq=0 one cycle later.
